dec16_counter: RTL and testbench
================================

// Module: dec16_counter
// PURPOSE
//   Registered loadable down-counter: the decrementing counterpart of Inc16.
//   Holds a WIDTH-bit value and subtracts 1 on request, with load, hold, zero-detect and borrow.
//   Serves countdown loops, stack-pointer pops and timers in the Hack platform datapath.
//   Priority follows the PC register: reset > load > dec > hold.
// PARAMETERS
//   WIDTH   16   counter / data width in bits (>= 2)
// PORTS
//   clk        in   1      rising-edge clock; the only clock
//   reset      in   1      asynchronous, active-high; clears all state immediately
//   load       in   1      out <= in at next clk edge
//   dec        in   1      out <= out - 1 at next clk edge (ignored when load=1)
//   in         in   WIDTH  load value (two's complement or unsigned; treated as raw bits)
//   out        out  WIDTH  registered counter value
//   zero       out  1      combinational: 1 when out == 0
//   borrow     out  1      registered 1-cycle pulse: a dec was applied while out == 0
//   underflow  out  1      registered sticky flag: set with borrow, cleared by load or reset
// BEHAVIOUR
//   - Reset (async, any time): out=0, borrow=0, underflow=0 at once; zero=1 follows combinationally.
//   - Reset mid-count discards the value; counting resumes only after reset deasserts and a
//     later edge sees load/dec.
//   - Per rising edge, reset low:
//       load=1         : out<=in; borrow<=0; underflow<=0 (load wins over dec)
//       load=0,dec=1   : out<=out-1 mod 2^WIDTH; borrow<=(out==0); underflow<=underflow|(out==0)
//       load=0,dec=0   : out holds; borrow<=0; underflow holds
//   - Latency: 1 cycle from load/dec sampled to new out; zero valid same cycle as out.
//   - Wrap-around: dec at 0 gives all-ones (16'hFFFF = -1 signed) and borrow=1 for one cycle.
//   - Back-to-back dec decrements every cycle; borrow never stays high two cycles unless
//     out was 0 on both edges (only possible with SATURATE_EN).
//   - Arithmetic is WIDTH-bit modular subtraction; no sign extension; in/out carry raw bits.
//   - Inputs are sampled only at the clock edge; no combinational path from in/load/dec to out.
// CONFIGURATION
//   DEC16_SATURATE_EN defined:
//     dec at out==0 leaves out at 0 (no wrap); borrow still pulses, underflow still sets.
//     Held dec at 0 pulses borrow on every such edge.
//   DEC16_SATURATE_EN undefined (default):
//     modular wrap as above; identical to WIDTH-bit subtract-one.
// TESTING
//   1. reset pulse, then load in=14 -> out=14; dec x1 -> out=13, zero=0, borrow=0.
//   2. load in=-59 (16'hFFC5), dec x3 -> out=-62 (16'hFFC2); dec=0 for 5 cycles -> out holds -62.
//   3. load in=1, dec x2 -> out=0 with zero=1, then out=16'hFFFF, borrow=1 for exactly one
//      cycle, underflow=1; load in=0 -> underflow=0.
//      With DEC16_SATURATE_EN: out stays 0, borrow=1, underflow=1.
//   4. load=1, dec=1 same edge with in=-1245 -> out=-1245 (load wins); next edge dec only -> -1246.
//   5. load in=500, dec for 10 cycles, assert reset between edges -> out=0, zero=1,
//      borrow=0, underflow=0 before next edge; after release with no load/dec, out stays 0.

Source files
------------

// File: rtl/dec16_counter_if.sv
// Control/data bundle for dec16_counter: load/dec/in toward the counter,
// out/zero/borrow/underflow back from it.
interface dec16_counter_if #(
    parameter int WIDTH = 16
);
  logic             load;
  logic             dec;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             borrow;
  logic             underflow;

  modport master (
    output load,
    output dec,
    output in,
    input  out,
    input  zero,
    input  borrow,
    input  underflow
  );

  modport slave (
    input  load,
    input  dec,
    input  in,
    output out,
    output zero,
    output borrow,
    output underflow
  );
endinterface

// File: rtl/dec16_counter.sv
// Registered loadable down-counter with zero detect, borrow pulse and sticky underflow.
// Optional macro DEC16_SATURATE_EN: decrement at zero holds 0 instead of wrapping.
module dec16_counter #(
    parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            reset,
  dec16_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] out_next;
  logic             borrow_reg;
  logic             borrow_next;
  logic             underflow_reg;
  logic             underflow_next;
  logic             at_zero;

  assign at_zero = (out_reg == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg       <= '0;
      borrow_reg    <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      out_reg       <= out_next;
      borrow_reg    <= borrow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Priority: load over dec over hold; borrow only lives for the edge that caused it.
  always_comb begin
    out_next       = out_reg;
    borrow_next    = 1'b0;
    underflow_next = underflow_reg;
    if (bus.load) begin
      out_next       = bus.in;
      underflow_next = 1'b0;
    end else if (bus.dec) begin
      borrow_next    = at_zero;
      underflow_next = underflow_reg | at_zero;
`ifdef DEC16_SATURATE_EN
      out_next       = at_zero ? '0 : (out_reg - ONE);
`else
      out_next       = out_reg - ONE;
`endif
    end
  end

  assign bus.out       = out_reg;
  assign bus.zero      = at_zero;
  assign bus.borrow    = borrow_reg;
  assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_dec16_counter.sv
// Scoreboard bench for dec16_counter: driver queues hand-computed expectations,
// monitor pops and compares after each clock edge or reset assertion.
module tb_dec16_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;

  dec16_counter_if #(.WIDTH(16)) bus ();

  dec16_counter #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  string       name_q[$];
  logic [18:0] exp_q[$];
  int          tests  = 0;
  int          errors = 0;

  // Expected vector packing: {out[15:0], zero, borrow, underflow}
  function automatic logic [18:0] pack(input logic [15:0] o, input logic b, input logic u);
    return {o, (o == 16'h0000), b, u};
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() > 0) begin
        string       nm;
        logic [18:0] ex;
        logic [18:0] act;
        nm  = name_q.pop_front();
        ex  = exp_q.pop_front();
        act = {bus.out, bus.zero, bus.borrow, bus.underflow};
        tests++;
        if (act !== ex) begin
          errors++;
          $display("FAIL %s: out=%h zero=%b borrow=%b underflow=%b, required out=%h zero=%b borrow=%b underflow=%b",
                   nm, act[18:3], act[2], act[1], act[0], ex[18:3], ex[2], ex[1], ex[0]);
        end else begin
          $display("[TB] ok   %s: out=%h zero=%b borrow=%b underflow=%b",
                   nm, act[18:3], act[2], act[1], act[0]);
        end
      end
    end
  end

  task automatic step(input logic ld, input logic dc, input logic [15:0] v, input string nm,
                      input logic [15:0] eo, input logic eb, input logic eu);
    @(negedge clk);
    bus.load = ld;
    bus.dec  = dc;
    bus.in   = v;
    name_q.push_back(nm);
    exp_q.push_back(pack(eo, eb, eu));
  endtask

  // Asynchronous reset between edges, with dec still requested.
  task automatic reset_mid(input string nm);
    @(negedge clk);
    bus.load = 1'b0;
    bus.dec  = 1'b1;
    #2;
    name_q.push_back(nm);
    exp_q.push_back(pack(16'h0000, 1'b0, 1'b0));
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    bus.dec = 1'b0;
  endtask

  initial begin
    bus.load = 1'b0;
    bus.dec  = 1'b0;
    bus.in   = 16'h0000;
    #1;
    name_q.push_back("reset_state");
    exp_q.push_back(pack(16'h0000, 1'b0, 1'b0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    step(1, 0, 16'd14,   "load_14",  16'd14, 0, 0);
    step(0, 1, 16'd0,    "dec_13",   16'd13, 0, 0);

    step(1, 0, 16'hFFC5, "load_m59", 16'hFFC5, 0, 0);
    step(0, 1, 16'd0,    "dec_m60",  16'hFFC4, 0, 0);
    step(0, 1, 16'd0,    "dec_m61",  16'hFFC3, 0, 0);
    step(0, 1, 16'd0,    "dec_m62",  16'hFFC2, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 16'd0, "hold_m62", 16'hFFC2, 0, 0);

    step(1, 0, 16'd1,    "load_1",   16'd1, 0, 0);
    step(0, 1, 16'd0,    "dec_to_0", 16'd0, 0, 0);
`ifdef DEC16_SATURATE_EN
    step(0, 1, 16'd0,    "dec_at_0", 16'h0000, 1, 1);
    step(0, 1, 16'd0,    "dec_at_0_again", 16'h0000, 1, 1);
    step(0, 0, 16'd0,    "hold_after_borrow", 16'h0000, 0, 1);
`else
    step(0, 1, 16'd0,    "wrap_ffff", 16'hFFFF, 1, 1);
    step(0, 1, 16'd0,    "dec_fffe_sticky", 16'hFFFE, 0, 1);
    step(0, 0, 16'd0,    "hold_after_borrow", 16'hFFFE, 0, 1);
`endif
    step(1, 0, 16'd0,    "load_0_clears_uf", 16'h0000, 0, 0);

    step(1, 1, 16'hFB23, "load_wins_m1245", 16'hFB23, 0, 0);
    step(0, 1, 16'd0,    "dec_m1246", 16'hFB22, 0, 0);

    step(1, 0, 16'd500,  "load_500", 16'd500, 0, 0);
    for (int i = 1; i <= 10; i++) step(0, 1, 16'd0, "dec_run", 16'(500 - i), 0, 0);
    reset_mid("reset_mid_count");
    step(0, 0, 16'd0,    "idle_after_reset", 16'h0000, 0, 0);
    step(0, 0, 16'd0,    "idle_after_reset2", 16'h0000, 0, 0);

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        tests++;
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
